pc_branch_unit: RTL and testbench

Program-counter and control-flow stage sitting directly downstream of the ALU in the single-cycle MIPS datapath. Consumes the ALU `ZERO` flag together with decoded branch/jump controls and updates the word-addressed PC every clock. Also owns the processor run state (run, wait-for-input, halted), so the instruction memory, display and register file see one authoritative PC and halt indication.

---
 rtl/pc_branch_unit_pkg.sv | 18 +
 rtl/pc_branch_unit_next_sel.sv | 42 ++++
 rtl/pc_branch_unit.sv | 133 +++++++++++++
 tb/tb_pc_branch_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_branch_unit_pkg.sv
// Shared types and constants for the PC / control-flow stage (pc_branch_unit).
// Holds the run-state encoding, the reset PC default, the counter width and the branch-offset sign-extension helper.
package pc_branch_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT_IN = 2'd1,
    ST_HALTED  = 2'd2
  } run_state_e;

  localparam int DEFAULT_RESET_PC = 0;
  localparam int TAKEN_CNT_W      = 16;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/pc_branch_unit_next_sel.sv
// Combinational next-PC selection for a running, non-stalled cycle: jr > j > taken branch > pc+1.
// Zero latency, no flow control; halt and wait handling are left to the caller.
module pc_next_sel
  import pc_branch_unit_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              jump_reg,
  input  logic              jump,
  input  logic              branch,
  input  logic              zero,
  input  logic [15:0]       imm,
  input  logic [25:0]       jump_target,
  input  logic [31:0]       reg_target,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic [ADDR_W-1:0] pc_target
);

  logic [31:0]       imm_ext;
  logic [ADDR_W-1:0] br_target;
  logic              unused_bits;

  assign imm_ext   = sext16(imm);
  assign pc_plus1  = pc + ADDR_W'(1);
  // Offset is relative to pc+1 and wraps modulo 2^ADDR_W.
  assign br_target = pc_plus1 + imm_ext[ADDR_W-1:0];

  assign unused_bits = ^{imm_ext[31:ADDR_W], reg_target[31:ADDR_W], jump_target[25:ADDR_W]};

  always_comb begin
    pc_target = pc_plus1;
    if (jump_reg) begin
      pc_target = reg_target[ADDR_W-1:0];
    end else if (jump) begin
      pc_target = jump_target[ADDR_W-1:0];
    end else if (branch && zero) begin
      pc_target = br_target;
    end
  end

endmodule

// File: rtl/pc_branch_unit.sv
// PC register and RUN/WAIT_IN/HALTED run-state FSM; decisions in cycle N show on pc in N+1, stall holds everything.
// Optional taken-branch counter enabled by `define PC_BRANCH_COUNT_EN (otherwise taken_count is tied to 0).
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   stall,
  input  logic                   zero,
  input  logic                   branch,
  input  logic                   jump,
  input  logic                   jump_reg,
  input  logic                   halt,
  input  logic                   input_req,
  input  logic                   input_ack,
  input  logic [15:0]            imm,
  input  logic [25:0]            jump_target,
  input  logic [31:0]            reg_target,
  output logic [ADDR_W-1:0]      pc,
  output logic [ADDR_W-1:0]      pc_plus1,
  output logic                   waiting,
  output logic                   halted,
  output logic                   retire,
  output logic [TAKEN_CNT_W-1:0] taken_count
);

  run_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_target;
  logic              waiting_q, waiting_d;
  logic              halted_q, halted_d;
  logic              retire_c;
  logic              run_go;

  pc_next_sel #(.ADDR_W(ADDR_W)) u_next_sel (
    .pc          (pc_q),
    .jump_reg    (jump_reg),
    .jump        (jump),
    .branch      (branch),
    .zero        (zero),
    .imm         (imm),
    .jump_target (jump_target),
    .reg_target  (reg_target),
    .pc_plus1    (pc_plus1),
    .pc_target   (pc_target)
  );

  assign run_go = (state_q == ST_RUN) && !stall && !halt && !input_req;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    retire_c = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (!stall) begin
          if (halt) begin
            state_d = ST_HALTED;
          end else if (input_req) begin
            state_d = ST_WAIT_IN;
          end else begin
            pc_d     = pc_target;
            retire_c = 1'b1;
          end
        end
      end
      ST_WAIT_IN: begin
        if (input_ack) begin
          pc_d     = pc_plus1;
          state_d  = ST_RUN;
          retire_c = 1'b1;
        end
      end
      default: begin
        state_d = ST_HALTED;
      end
    endcase
    waiting_d = (state_d == ST_WAIT_IN);
    halted_d  = (state_d == ST_HALTED);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_RUN;
      pc_q      <= ADDR_W'(RESET_PC);
      waiting_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      waiting_q <= waiting_d;
      halted_q  <= halted_d;
    end
  end

`ifdef PC_BRANCH_COUNT_EN
  logic [TAKEN_CNT_W-1:0] cnt_q, cnt_d;
  logic                   br_taken;

  assign br_taken = run_go && !jump_reg && !jump && branch && zero;

  always_comb begin
    cnt_d = cnt_q;
    if (br_taken && (cnt_q != '1)) begin
      cnt_d = cnt_q + TAKEN_CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign taken_count = cnt_q;
`else
  logic unused_run_go;
  assign unused_run_go = run_go;
  assign taken_count   = '0;
`endif

  assign pc      = pc_q;
  assign waiting = waiting_q;
  assign halted  = halted_q;
  // Gated so nothing retires while reset is held.
  assign retire  = retire_c && reset_n;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: integer-arithmetic reference model checked every negedge, plus literal pins.
module tb_pc_branch_unit;

  localparam int AW   = 10;
  localparam int MASK = (1 << AW) - 1;
`ifdef PC_BRANCH_COUNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif
  localparam int M_RUN = 0, M_WAIT = 1, M_HALT = 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          stall = 0, zero = 0, branch = 0, jump = 0, jump_reg = 0;
  logic          halt = 0, input_req = 0, input_ack = 0;
  logic [15:0]   imm = '0;
  logic [25:0]   jump_target = '0;
  logic [31:0]   reg_target = '0;
  logic [AW-1:0] pc, pc_plus1;
  logic          waiting, halted, retire;
  logic [15:0]   taken_count;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;

  int m_pc = 0;
  int m_mode = M_RUN;
  int m_cnt = 0;

  pc_branch_unit #(.ADDR_W(AW), .RESET_PC(0)) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall), .zero(zero), .branch(branch),
    .jump(jump), .jump_reg(jump_reg), .halt(halt), .input_req(input_req),
    .input_ack(input_ack), .imm(imm), .jump_target(jump_target), .reg_target(reg_target),
    .pc(pc), .pc_plus1(pc_plus1), .waiting(waiting), .halted(halted), .retire(retire),
    .taken_count(taken_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_retire();
    if (!reset_n) return 0;
    if (m_mode == M_RUN) return !stall && !halt && !input_req;
    if (m_mode == M_WAIT) return input_ack;
    return 0;
  endfunction

  // Reference model: next PC straight from the instruction semantics.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_pc = 0; m_mode = M_RUN; m_cnt = 0;
    end else if (m_mode == M_WAIT) begin
      if (input_ack) begin m_pc = (m_pc + 1) & MASK; m_mode = M_RUN; end
    end else if (m_mode == M_RUN && !stall) begin
      if (halt) m_mode = M_HALT;
      else if (input_req) m_mode = M_WAIT;
      else if (jump_reg) m_pc = int'(reg_target) & MASK;
      else if (jump) m_pc = int'(jump_target) & MASK;
      else if (branch && zero) begin
        m_pc = (m_pc + 1 + int'($signed(imm))) & MASK;
        if (CNT_ON == 1 && m_cnt < 65535) m_cnt++;
      end else m_pc = (m_pc + 1) & MASK;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("pc", 32'(pc), 32'(m_pc));
      chk("pc_plus1", 32'(pc_plus1), 32'((m_pc + 1) & MASK));
      chk("waiting", 32'(waiting), 32'(m_mode == M_WAIT));
      chk("halted", 32'(halted), 32'(m_mode == M_HALT));
      chk("retire", 32'(retire), 32'(model_retire()));
      chk("taken_count", 32'(taken_count), 32'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    stall = 0; zero = 0; branch = 0; jump = 0; jump_reg = 0;
    halt = 0; input_req = 0; input_ack = 0;
  endtask

  initial begin
    @(posedge clock);
    #1;
    chk_en = 1;
    chk("rst_pc", 32'(pc), 0);
    chk("rst_waiting", 32'(waiting), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_retire", 32'(retire), 0);
    chk("rst_count", 32'(taken_count), 0);
    reset_n = 1;
    #1 chk("seq_retire", 32'(retire), 1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("seq_pc", 32'(pc), 32'(i));
    end
    tick(); tick();
    chk("at5", 32'(pc), 5);

    branch = 1; zero = 1; imm = 16'hFFFD;
    tick();
    chk("br_taken_pc", 32'(pc), 3);
    chk("br_taken_cnt", 32'(taken_count), 32'(CNT_ON));
    clr();
    tick(); tick();
    branch = 1; zero = 0;
    tick();
    chk("br_not_taken_pc", 32'(pc), 6);
    chk("br_not_taken_cnt", 32'(taken_count), 32'(CNT_ON));
    clr();

    jump = 1; jump_target = 26'd1023;
    tick();
    chk("j_1023", 32'(pc), 1023);
    chk("plus1_wrap", 32'(pc_plus1), 0);
    clr();
    tick();
    chk("seq_wrap", 32'(pc), 0);
    jump = 1; jump_target = 26'd1022;
    tick();
    clr(); branch = 1; zero = 1; imm = 16'd2;
    tick();
    chk("br_wrap", 32'(pc), 1);
    clr();

    jump = 1; branch = 1; zero = 1; jump_target = 26'h40;
    tick();
    chk("j_over_br", 32'(pc), 32'h40);
    clr(); stall = 1; jump = 1; jump_target = 26'h99;
    #1 chk("stall_retire", 32'(retire), 0);
    tick();
    chk("stall_hold", 32'(pc), 32'h40);
    clr(); jump_reg = 1; jump = 1; reg_target = 32'hFFFF_F008;
    tick();
    chk("jr_pc", 32'(pc), 8);
    clr();

    input_req = 1; input_ack = 1;
    tick();
    chk("wait_enter", 32'(waiting), 1);
    chk("wait_pc", 32'(pc), 8);
    for (int i = 0; i < 10; i++) begin
      clr(); jump = 1; branch = 1; zero = 1; stall = i[0]; input_req = 1; halt = i[1];
      tick();
      chk("wait_hold_pc", 32'(pc), 8);
    end
    clr(); input_ack = 1;
    #1 chk("ack_retire", 32'(retire), 1);
    tick();
    chk("ack_pc", 32'(pc), 9);
    chk("ack_waiting", 32'(waiting), 0);
    clr(); input_req = 1;
    tick();
    clr();
    chk("wait2", 32'(waiting), 1);
    #1 reset_n = 0;
    #1;
    chk("wait_rst_pc", 32'(pc), 0);
    chk("wait_rst_waiting", 32'(waiting), 0);
    tick();
    reset_n = 1;

    jump = 1; jump_target = 26'd12;
    tick();
    clr(); halt = 1;
    tick();
    chk("halt_enter", 32'(halted), 1);
    chk("halt_pc", 32'(pc), 12);
    for (int i = 0; i < 5; i++) begin
      clr(); jump = 1; jump_target = 26'h55; input_ack = 1; input_req = i[0];
      branch = 1; zero = 1;
      tick();
      chk("halt_hold_pc", 32'(pc), 12);
    end
    clr();
    #1 reset_n = 0;
    #1;
    chk("halt_rst", 32'(halted), 0);
    chk("halt_rst_pc", 32'(pc), 0);
    tick();
    reset_n = 1;
    tick();
    chk("post_rst_pc", 32'(pc), 1);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
